riscv_muldiv_alu: RTL and testbench
===================================

RISCV_MULDIV_ALU -- requirements
Module: riscv_muldiv_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (power of two, >=8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready both high at a clk edge.
REQ-006 SHALL have port op  input  5  operation code.
REQ-007 SHALL have ports a and b  input  XLEN  operands.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  XLEN  registered result.
REQ-011 SHALL have port zero  output  1  high when result == 0.
REQ-012 SHALL have port illegal  output  1  undefined or compiled-out op.

Function
REQ-013 SHALL decode single-cycle ops: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 00111 SLT (signed), 01100 NOR, 00011 XOR, 00100 SLL, 00101 SRL, 01101 SRA, 01000 SLTU.
REQ-014 SHALL decode multi-cycle ops: 10000 MUL (low XLEN), 10001 MULH (signed high), 10010 MULHU (unsigned high), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-015 SHALL use b[log2(XLEN)-1:0] as the shift amount; ADD/SUB wrap modulo 2^XLEN; SLT/SLTU return 1 or 0.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-017 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-018 SHALL, for single-cycle ops accepted at edge N, enter DONE with out_valid=1 at edge N+1.
REQ-019 SHALL compute MUL* with an iterative shift-add over operand magnitudes, one bit per cycle, for XLEN cycles, followed by one sign-fixup cycle; out_valid rises at edge N+XLEN+2.
REQ-020 SHALL compute DIV*/REM* with restoring division, one quotient bit per cycle, for XLEN cycles, followed by one sign-fixup cycle; out_valid rises at edge N+XLEN+2.
REQ-021 SHALL return quotient all-ones and remainder = a for a divisor of zero, with the same latency.
REQ-022 SHALL return quotient = a and remainder 0 for signed overflow (a = -2^(XLEN-1), b = -1).
REQ-023 SHALL give the remainder the sign of the dividend and truncate the quotient toward zero.
REQ-024 SHALL, for an undefined op, complete as a single-cycle op with result 0, zero=1 and illegal=1.
REQ-025 SHALL hold result, zero, illegal and out_valid stable in DONE until out_ready=1.
REQ-026 SHALL, in DONE with out_ready=1 and in_valid=1, retire the result and accept the new request on the same edge (back-to-back; no bubble for single-cycle ops).
REQ-027 SHALL ignore in_valid while in MUL or DIV; operands are latched at acceptance.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, out_valid 0, result 0, zero 1, illegal 0 and clear iteration counters; in_ready becomes 1 once reset releases.
REQ-029 SHALL abort an in-flight multi-cycle operation when reset is asserted; no result is ever produced for the aborted operation.

Configuration
REQ-030 SHALL compile the divider in only when macro RISCV_MULDIV_DIV_EN is defined.
REQ-031 SHALL, without RISCV_MULDIV_DIV_EN, treat op 101xx as undefined per REQ-024 and contain no DIV state logic.

Structure
REQ-032 SHALL place the op-code enum, the FSM state enum and the XLEN default in package riscv_alu_pkg.
REQ-033 SHALL instantiate sub-module riscv_alu_comb for the single-cycle datapath; the sequencer, multiplier and divider stay in the top module.

Verification
REQ-034 Bench SHALL check: ADD a=9 b=1 -> result=10, zero=0, out_valid at edge N+1; SUB a=8 b=8 -> result=0, zero=1.
REQ-035 Bench SHALL check: SLT a=0xFFFFFFFF b=1 -> 1; SLTU with the same operands -> 0; SRA a=0x80000000 b=4 -> 0xF8000000.
REQ-036 Bench SHALL check: MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0, and MUL with the same operands -> 1; out_valid exactly 34 cycles after acceptance (XLEN=32).
REQ-037 Bench SHALL check: DIV a=-7 b=2 -> -3 and REM -> -1; DIVU a=7 b=0 -> 0xFFFFFFFF; REM a=0x80000000 b=-1 -> 0.
REQ-038 Bench SHALL check: out_ready held low 5 cycles in DONE -> result stable; then out_ready=1 with in_valid=1 OR -> accepted on the same edge.
REQ-039 Bench SHALL check: rst_n pulsed low mid-DIV -> out_valid=0 and in_ready=1 after release, no stale result; rebuild without the macro -> DIV gives illegal=1 and result=0 at N+1.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared op-code and sequencer state types for the RV-style mul/div ALU.
// No logic here; latency and backpressure are defined by riscv_muldiv_alu.
// Op helpers classify the 5-bit op field into multi-cycle groups.
package riscv_alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_AND   = 5'b00000,
        OP_OR    = 5'b00001,
        OP_ADD   = 5'b00010,
        OP_XOR   = 5'b00011,
        OP_SLL   = 5'b00100,
        OP_SRL   = 5'b00101,
        OP_SUB   = 5'b00110,
        OP_SLT   = 5'b00111,
        OP_SLTU  = 5'b01000,
        OP_NOR   = 5'b01100,
        OP_SRA   = 5'b01101,
        OP_MUL   = 5'b10000,
        OP_MULH  = 5'b10001,
        OP_MULHU = 5'b10010,
        OP_DIV   = 5'b10100,
        OP_DIVU  = 5'b10101,
        OP_REM   = 5'b10110,
        OP_REMU  = 5'b10111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } alu_state_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op[4:2] == 3'b100) && (op[1:0] != 2'b11);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

endpackage

// File: rtl/riscv_alu_comb.sv
// Single-cycle ALU datapath: logic, add/sub, compares and shifts.
// Purely combinational; no latency, no backpressure (sequencer registers the result).
// single=0 flags any op this datapath does not implement.
module riscv_alu_comb
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            single
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    assign shamt = b[SW-1:0];

    always_comb begin
        y      = '0;
        single = 1'b1;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            OP_NOR:  y = ~(a | b);
            OP_SRA:  y = $signed(a) >>> shamt;
            default: single = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_muldiv_alu.sv
// ALU with iterative shift-add multiplier and (with RISCV_MULDIV_DIV_EN) restoring divider.
// Latency: single-cycle ops visible 1 edge after acceptance, mul/div XLEN+2 edges.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or retiring DONE.
module riscv_muldiv_alu
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN + 1);

    alu_state_t state, state_nxt, launch_state;

    logic [XLEN-1:0]   alu_y;
    logic              alu_single;
    logic              accept;
    logic              start_mul;
    logic              start_div;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              mul_signed_in;

    logic [CW-1:0]     cnt;
    logic [1:0]        op_lo_q;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              illegal_q;

    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;

    riscv_alu_comb #(.XLEN(XLEN)) u_comb (
        .op     (op),
        .a      (a),
        .b      (b),
        .y      (alu_y),
        .single (alu_single)
    );

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    assign start_mul     = is_mul_op(op);
    assign a_abs         = a[XLEN-1] ? -a : a;
    assign b_abs         = b[XLEN-1] ? -b : b;
    assign mul_signed_in = (op[1:0] == 2'b01);

    // Only MULH works on magnitudes; MUL low bits are sign-agnostic.
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : {XLEN{1'b0}})};
    assign prod_fix = neg_q ? -prod : prod;
    assign mul_res  = (op_lo_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef RISCV_MULDIV_DIV_EN
    logic [XLEN-1:0] dvs, rem, quo, a_q;
    logic            rneg_q, div0_q, div_signed_in;
    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] q_fix, r_fix, div_res;

    assign start_div     = is_div_op(op);
    assign div_signed_in = !op[0];
    assign div_shift     = {rem, quo[XLEN-1]};
    assign div_diff      = div_shift - {1'b0, dvs};

    always_comb begin
        q_fix = neg_q ? -quo : quo;
        r_fix = rneg_q ? -rem : rem;
        if (div0_q) begin
            q_fix = '1;
            r_fix = a_q;
        end
        div_res = op_lo_q[1] ? r_fix : q_fix;
    end
`else
    assign start_div = 1'b0;
`endif

    always_comb begin
        launch_state = ST_DONE;
        if (start_mul) begin
            launch_state = ST_MUL;
        end
`ifdef RISCV_MULDIV_DIV_EN
        else if (start_div) begin
            launch_state = ST_DIV;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = launch_state;
            ST_DONE: if (out_ready) state_nxt = in_valid ? launch_state : ST_IDLE;
            ST_MUL:  if (cnt == CW'(XLEN)) state_nxt = ST_DONE;
`ifdef RISCV_MULDIV_DIV_EN
            ST_DIV:  if (cnt == CW'(XLEN)) state_nxt = ST_DONE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_lo_q   <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            mcand     <= '0;
            prod      <= '0;
`ifdef RISCV_MULDIV_DIV_EN
            dvs       <= '0;
            rem       <= '0;
            quo       <= '0;
            a_q       <= '0;
            rneg_q    <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= '0;
                op_lo_q <= op[1:0];
                if (start_mul) begin
                    mcand <= mul_signed_in ? a_abs : a;
                    prod  <= {{XLEN{1'b0}}, (mul_signed_in ? b_abs : b)};
                    neg_q <= mul_signed_in && (a[XLEN-1] ^ b[XLEN-1]);
                end
`ifdef RISCV_MULDIV_DIV_EN
                else if (start_div) begin
                    quo    <= div_signed_in ? a_abs : a;
                    dvs    <= div_signed_in ? b_abs : b;
                    rem    <= '0;
                    neg_q  <= div_signed_in && (a[XLEN-1] ^ b[XLEN-1]);
                    rneg_q <= div_signed_in && a[XLEN-1];
                    div0_q <= (b == '0);
                    a_q    <= a;
                end
`endif
                else begin
                    // Undefined ops retire like single-cycle ops with a zero result.
                    result_q  <= alu_single ? alu_y : '0;
                    zero_q    <= !alu_single || (alu_y == '0);
                    illegal_q <= !alu_single;
                end
            end else if (state == ST_MUL) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(XLEN)) begin
                    result_q  <= mul_res;
                    zero_q    <= (mul_res == '0);
                    illegal_q <= 1'b0;
                end else begin
                    prod <= {mul_sum, prod[XLEN-1:1]};
                end
            end
`ifdef RISCV_MULDIV_DIV_EN
            else if (state == ST_DIV) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(XLEN)) begin
                    result_q  <= div_res;
                    zero_q    <= (div_res == '0);
                    illegal_q <= 1'b0;
                end else if (!div_diff[XLEN]) begin
                    rem <= div_diff[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b1};
                end else begin
                    rem <= div_shift[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b0};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_alu.sv
// Directed self-checking bench for riscv_muldiv_alu (XLEN=32), divider checks
// follow RISCV_MULDIV_DIV_EN so the same bench covers both builds.
module tb_riscv_muldiv_alu;
    import riscv_alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_tests;
    int n_fail;
    int lat;

    riscv_muldiv_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request, waits for acceptance, then counts edges until out_valid is seen.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int l);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        w  = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        issue(OP_ADD, 32'd9, 32'd1, lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_res", result, 32'd10);
        check("add_zero", 32'(zero), 32'd0);
        check("add_in_ready_hold", 32'(in_ready), 32'd0);
        retire();

        issue(OP_SUB, 32'd8, 32'd8, lat);
        check("sub_res", result, 32'd0);
        check("sub_zero", 32'(zero), 32'd1);
        retire();

        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat);
        check("slt_res", result, 32'd1);
        retire();
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, lat);
        check("sltu_res", result, 32'd0);
        retire();
        issue(OP_SRA, 32'h8000_0000, 32'd4, lat);
        check("sra_res", result, 32'hF800_0000);
        retire();
        issue(OP_SRL, 32'h8000_0000, 32'd36, lat);
        check("srl_shamt_wrap", result, 32'h0800_0000);
        retire();

        issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mulh_lat", 32'(lat), 32'd34);
        check("mulh_res", result, 32'd0);
        check("mulh_zero", 32'(zero), 32'd1);
        retire();
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mul_lat", 32'(lat), 32'd34);
        check("mul_res", result, 32'd1);
        retire();
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mulhu_res", result, 32'hFFFF_FFFE);
        retire();
        issue(OP_MULH, 32'hFFFF_FFF9, 32'd3, lat);
        check("mulh_neg_res", result, 32'hFFFF_FFFF);
        retire();

`ifdef RISCV_MULDIV_DIV_EN
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", 32'(lat), 32'd34);
        check("div_res", result, 32'hFFFF_FFFD);
        check("div_illegal", 32'(illegal), 32'd0);
        retire();
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, lat);
        check("rem_res", result, 32'hFFFF_FFFF);
        retire();
        issue(OP_DIVU, 32'd7, 32'd0, lat);
        check("divu0_lat", 32'(lat), 32'd34);
        check("divu0_res", result, 32'hFFFF_FFFF);
        retire();
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("rem_ovf_res", result, 32'd0);
        check("rem_ovf_zero", 32'(zero), 32'd1);
        retire();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_ovf_res", result, 32'h8000_0000);
        retire();
        issue(OP_REMU, 32'd100, 32'd7, lat);
        check("remu_res", result, 32'd2);
        retire();
`else
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        check("nodiv_lat", 32'(lat), 32'd1);
        check("nodiv_illegal", 32'(illegal), 32'd1);
        check("nodiv_res", result, 32'd0);
        check("nodiv_zero", 32'(zero), 32'd1);
        retire();
`endif

        issue(5'b11111, 32'd5, 32'd6, lat);
        check("undef_lat", 32'(lat), 32'd1);
        check("undef_res", result, 32'd0);
        check("undef_zero", 32'(zero), 32'd1);
        check("undef_illegal", 32'(illegal), 32'd1);
        retire();

        issue(OP_ADD, 32'd5, 32'd6, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_res", result, 32'd11);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = OP_OR;
        a         = 32'h0000_00F0;
        b         = 32'h0000_000F;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_res", result, 32'h0000_00FF);
        check("b2b_illegal", 32'(illegal), 32'd0);
        retire();

        @(negedge clk);
        in_valid = 1'b1;
`ifdef RISCV_MULDIV_DIV_EN
        op = OP_DIV;
`else
        op = OP_MUL;
`endif
        a = 32'd100;
        b = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid_in_rst", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_res", result, 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        issue(OP_XOR, 32'h0000_FFFF, 32'h0000_0F0F, lat);
        check("post_abort_lat", 32'(lat), 32'd1);
        check("post_abort_res", result, 32'h0000_F0F0);
        retire();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
